// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache fill controller.
// Build option: CACHE_FILL_CWF_EN selects critical-word-first fill order.
package cache_pkg;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 16;
   localparam int WORDS      = 8;
   localparam int OFFSET_W   = $clog2(WORDS * 2);
   localparam int WORD_IDX_W = $clog2(WORDS);
   localparam int BASE_W     = ADDR_W - OFFSET_W;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

endpackage

// File: rtl/cache_fill_fsm_if.sv
// Bus bundle between the fill controller and the cache/memory side.
// master: the fill controller. slave: the cache arrays, memory and pipeline.
interface cache_fill_fsm_if;
   import cache_pkg::*;

   logic                  miss_detected;
   logic [ADDR_W-1:0]     miss_address;
   logic [DATA_W-1:0]     memory_data;
   logic                  memory_data_valid;
   logic                  fsm_busy;
   logic                  write_data_array;
   logic                  write_tag_array;
   logic [ADDR_W-1:0]     memory_address;
   logic [WORD_IDX_W-1:0] word_num;

   modport master (
      input  miss_detected, miss_address, memory_data, memory_data_valid,
      output fsm_busy, write_data_array, write_tag_array, memory_address, word_num
   );

   modport slave (
      output miss_detected, miss_address, memory_data, memory_data_valid,
      input  fsm_busy, write_data_array, write_tag_array, memory_address, word_num
   );

endinterface

// File: rtl/cache_fill_word_counter.sv
// Loadable word index within a block; advances on enable and wraps modulo WORDS.
module cache_fill_word_counter
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [WORD_IDX_W-1:0] load_val,
   input  logic                  en,
   output logic [WORD_IDX_W-1:0] idx
);

   logic [WORD_IDX_W-1:0] idx_q, idx_d;

   // Load has priority over advance; the adder wraps naturally at WORDS.
   always_comb begin
      idx_d = idx_q;
      if (load)
         idx_d = load_val;
      else if (en)
         idx_d = idx_q + 1'b1;
   end

   // Index register, cleared on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         idx_q <= '0;
      else
         idx_q <= idx_d;
   end

   assign idx = idx_q;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache-miss block fill controller: requests all words of the missing block,
// steers returned words into the data array and writes the tag on the last one.
// Build option: CACHE_FILL_CWF_EN starts at the missing word and wraps.
module cache_fill_fsm
   import cache_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   cache_fill_fsm_if.master  bus
);

   fill_state_e             state_q, state_d;
   logic [BASE_W-1:0]       base_q, base_d;
   logic [WORD_IDX_W:0]     rx_cnt_q, rx_cnt_d;
   logic [WORD_IDX_W-1:0]   req_cnt_q, req_cnt_d;

   logic                    start;
   logic                    accept;
   logic                    last_word;
   logic                    req_adv;
   logic [WORD_IDX_W-1:0]   start_idx;
   logic [WORD_IDX_W-1:0]   req_idx;
   logic [WORD_IDX_W-1:0]   rx_idx;

   assign start     = (state_q == IDLE) && bus.miss_detected;
   assign accept    = (state_q == FILL) && bus.memory_data_valid;
   assign last_word = accept && (rx_cnt_q == (WORDS - 1));
   // Stop advancing once every word of the block has been addressed, so the
   // final request address is held until the fill completes.
   assign req_adv   = (state_q == FILL) && (req_cnt_q != (WORDS - 1));

`ifdef CACHE_FILL_CWF_EN
   assign start_idx = bus.miss_address[OFFSET_W-1:1];
`else
   assign start_idx = '0;
`endif

   cache_fill_word_counter u_req_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .load_val (start_idx),
      .en       (req_adv),
      .idx      (req_idx)
   );

   cache_fill_word_counter u_rx_ctr (
      .clk      (clk),
      .rst      (rst),
      .load     (start),
      .load_val (start_idx),
      .en       (accept),
      .idx      (rx_idx)
   );

   // Next-state: latch the block base on a miss, count received words, return
   // to IDLE on the last one.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      rx_cnt_d  = rx_cnt_q;
      req_cnt_d = req_cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.miss_detected) begin
               state_d   = FILL;
               base_d    = bus.miss_address[ADDR_W-1:OFFSET_W];
               rx_cnt_d  = '0;
               req_cnt_d = '0;
            end
         end
         FILL: begin
            if (req_adv)
               req_cnt_d = req_cnt_q + 1'b1;
            if (accept)
               rx_cnt_d = rx_cnt_q + 1'b1;
            if (last_word)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         base_q    <= '0;
         rx_cnt_q  <= '0;
         req_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         rx_cnt_q  <= rx_cnt_d;
         req_cnt_q <= req_cnt_d;
      end
   end

   // Stall begins in the miss cycle itself so the pipeline never advances past it.
   assign bus.fsm_busy         = (state_q == FILL) || start;
   assign bus.write_data_array = accept;
   assign bus.write_tag_array  = last_word;
   assign bus.memory_address   = (state_q == FILL) ? {base_q, req_idx, 1'b0} : '0;
   assign bus.word_num         = (state_q == FILL) ? rx_idx : '0;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: expected data/tag writes are queued as
// valids are driven and retired when the controller issues the writes.
module tb_cache_fill_fsm;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   cache_fill_fsm_if bus ();

   cache_fill_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Scoreboard entry: {tag_expected, word_num}
   logic [3:0] sb_q [$];

   // Reference fill model, owned by the stimulus process.
   logic              m_busy;
   logic [BASE_W-1:0] m_base;
   logic [2:0]        m_start;
   int                m_rx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_miss(input logic [15:0] addr);
      bus.miss_address  = addr;
      bus.miss_detected = 1'b1;
      @(negedge clk);
      check("busy_on_miss", bus.fsm_busy, 1);
      step();
      bus.miss_detected = 1'b0;
      m_busy = 1'b1;
      m_base = addr[15:4];
`ifdef CACHE_FILL_CWF_EN
      m_start = addr[3:1];
`else
      m_start = 3'd0;
`endif
      m_rx = 0;
   endtask

   task automatic pulse_valid(input logic [15:0] data);
      bus.memory_data       = data;
      bus.memory_data_valid = 1'b1;
      if (m_busy) begin
         sb_q.push_back({(m_rx == 7), 3'(m_start + 3'(m_rx))});
         m_rx++;
         if (m_rx == 8)
            m_busy = 1'b0;
      end
      step();
      bus.memory_data_valid = 1'b0;
   endtask

   // Retire scoreboard entries as data writes appear.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.write_data_array) begin
            $display("wr word_num=%0d tag=%0d addr=%h", bus.word_num, bus.write_tag_array,
                     bus.memory_address);
            if (sb_q.size() == 0) begin
               check("unexpected_write", 1, 0);
            end else begin
               logic [3:0] e;
               e = sb_q.pop_front();
               check("word_num", bus.word_num, e[2:0]);
               check("tag_write", bus.write_tag_array, e[3]);
            end
         end else if (bus.write_tag_array) begin
            check("tag_without_data", 1, 0);
         end
      end
   end

   initial begin
      rst                   = 1'b1;
      bus.miss_detected     = 1'b0;
      bus.miss_address      = '0;
      bus.memory_data       = '0;
      bus.memory_data_valid = 1'b0;
      m_busy = 1'b0; m_base = '0; m_start = '0; m_rx = 0;

      // Reset state
      repeat (2) step();
      @(negedge clk);
      check("rst_busy", bus.fsm_busy, 0);
      check("rst_wda", bus.write_data_array, 0);
      check("rst_wta", bus.write_tag_array, 0);
      check("rst_addr", bus.memory_address, 0);
      check("rst_word", bus.word_num, 0);
      step();
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", bus.fsm_busy, 0);
      check("idle_addr", bus.memory_address, 0);
      step();

      // Basic fill: 10 valids, 5 cycles apart; last two must be ignored
      do_miss(16'h0000);
      for (int i = 0; i < 10; i++) begin
         repeat (4) step();
         pulse_valid(16'h4567);
      end
      @(negedge clk);
      check("basic_busy_after", bus.fsm_busy, 0);
      check("basic_sb_empty", sb_q.size(), 0);
      step();

      // Address sequence, then complete the fill back-to-back
      do_miss(16'hABCE);
      for (int k = 0; k < 10; k++) begin
         logic [2:0] wi;
         wi = m_start + 3'((k > 7) ? 7 : k);
         @(negedge clk);
         check("mem_addr", bus.memory_address, {m_base, wi, 1'b0});
         step();
      end
      for (int i = 0; i < 8; i++) pulse_valid(16'h1000 + 16'(i));
      @(negedge clk);
      check("addr_busy_after", bus.fsm_busy, 0);
      check("addr_sb_empty", sb_q.size(), 0);
      step();

      // Valid in IDLE is ignored
      bus.memory_data_valid = 1'b1;
      @(negedge clk);
      check("idle_valid_wr", bus.write_data_array, 0);
      check("idle_valid_busy", bus.fsm_busy, 0);
      step();
      bus.memory_data_valid = 1'b0;
      step();

      // Miss during fill is ignored
      do_miss(16'h5550);
      for (int i = 0; i < 3; i++) begin step(); pulse_valid(16'h2222); end
      bus.miss_address  = 16'h1230;
      bus.miss_detected = 1'b1;
      @(negedge clk);
      check("midmiss_busy", bus.fsm_busy, 1);
      step();
      bus.miss_detected = 1'b0;
      @(negedge clk);
      check("midmiss_base", bus.memory_address[15:4], 12'h555);
      step();
      for (int i = 0; i < 5; i++) begin step(); pulse_valid(16'h3333); end
      @(negedge clk);
      check("midmiss_busy_after", bus.fsm_busy, 0);
      check("midmiss_sb_empty", sb_q.size(), 0);
      step();

      // Reset mid-fill aborts without a tag write
      do_miss(16'h0040);
      for (int i = 0; i < 3; i++) begin step(); pulse_valid(16'h4444); end
      step();
      rst = 1'b1;
      #1;
      check("abort_busy", bus.fsm_busy, 0);
      check("abort_wta", bus.write_tag_array, 0);
      check("abort_addr", bus.memory_address, 0);
      check("abort_sb_empty", sb_q.size(), 0);
      m_busy = 1'b0;
      step();
      rst = 1'b0;
      step();
      do_miss(16'h0040);
      @(negedge clk);
      check("restart_addr", bus.memory_address, 16'h0040);
      step();
      for (int i = 0; i < 8; i++) begin step(); pulse_valid(16'h5555); end
      @(negedge clk);
      check("restart_busy_after", bus.fsm_busy, 0);
      check("restart_sb_empty", sb_q.size(), 0);
      step();

      // Mid-block miss: critical word first when enabled, word 0 otherwise
      do_miss(16'h00A6);
      @(negedge clk);
`ifdef CACHE_FILL_CWF_EN
      check("cwf_first_addr", bus.memory_address, 16'h00A6);
`else
      check("first_addr_a6", bus.memory_address, 16'h00A0);
`endif
      step();
      for (int i = 0; i < 8; i++) begin step(); pulse_valid(16'h6666); end
      @(negedge clk);
      check("a6_busy_after", bus.fsm_busy, 0);
      step();

      repeat (3) step();
      check("final_sb_empty", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
- Cache-miss fill controller for the 16-bit processor's I/D caches.
- On a miss it fetches the whole 16-byte block (8 x 16-bit words) from a pipelined main memory and steers each returned word into the cache data array.
- It writes the tag array when the final word lands and stalls the pipeline via fsm_busy while the fill is in progress.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, memory word width in bits.
- WORDS, 8, words per cache block; must be a power of two; block size is WORDS*2 bytes.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- miss_detected  input  1  cache lookup missed this cycle.
- miss_address  input  16  byte address of the missing access.
- memory_data  input  16  read data from memory; passes through to the cache data array externally.
- memory_data_valid  input  1  memory_data carries a returned word this cycle.
- fsm_busy  output  1  fill in progress; stall the pipeline.
- write_data_array  output  1  write memory_data into the data array at word_num.
- write_tag_array  output  1  write the tag/valid for the block being filled.
- memory_address  output  16  byte address of the current memory read request.
- word_num  output  3  word index (0..7) within the block for the current data write.

Behaviour:
- Reset is asynchronous and active-high, on rst. One clock, clk.
- Two states: IDLE and FILL. Reset enters IDLE and clears all counters and the latched base.
- All outputs are 0 while rst is high and in IDLE, except fsm_busy as defined below.
- IDLE -> FILL when miss_detected=1 at a clock edge.
  - At that edge, latch base = miss_address[15:4].
  - Clear req_idx, rx_idx and rx_cnt.
- fsm_busy (combinational) = (state==FILL) | (state==IDLE & miss_detected).
  - The stall therefore starts in the same cycle as the miss.
- FILL request side:
  - memory_address = {base, req_idx, 1'b0}.
  - req_idx increments every FILL cycle and saturates at 7, holding the last address.
  - Memory is pipelined (4-cycle latency); arbitrary valid spacing is tolerated.
- FILL receive side:
  - write_data_array = memory_data_valid & (state==FILL), combinational.
  - word_num = rx_idx.
  - On each accepted valid, rx_idx and rx_cnt increment.
- Completion:
  - On the valid that brings rx_cnt to 8, also assert write_tag_array in that same cycle.
  - FILL -> IDLE at that edge.
  - fsm_busy drops in the following cycle, unless a new miss is presented.
- memory_data_valid in IDLE is ignored: no writes and no state change.
- miss_detected during FILL is ignored; base is not re-latched.
- Exactly 8 data writes and 1 tag write per fill. Extra valids after completion are ignored.
- In IDLE: memory_address=16'h0000 and word_num=0.
- rst mid-fill aborts immediately; no tag write occurs.
- Counters are 3-bit for indices and 4-bit for rx_cnt; indices wrap modulo 8.

Optional Feature:
- Macro: CACHE_FILL_CWF_EN (critical-word-first).
- Defined:
  - req_idx and rx_idx initialise to miss_address[3:1] instead of 0.
  - Requests advance modulo 8 and stop after 8 issued, holding the last address.
  - word_num reports the true word index, wrapping 7->0.
  - Termination is still by rx_cnt==8.
- Undefined: fill always starts at word 0, in order.

Decomposition:
- Shared package cache_pkg holds:
  - a state enum {IDLE, FILL};
  - constants for ADDR_W, DATA_W, WORDS;
  - OFFSET_W = $clog2(WORDS*2);
  - WORD_IDX_W = $clog2(WORDS).
- One natural sub-module: cache_fill_word_counter, a loadable 3-bit index plus enable/wrap, instantiated twice (request and receive).

Test Plan:
- Reset then idle: rst=1 -> all outputs 0. With rst=0 and no miss -> fsm_busy=0 and memory_address=0.
- Basic fill:
  - Stimulus: miss_address=16'h0000; miss_detected for 1 cycle; 10 valid pulses of memory_data=16'h4567 every 5 cycles.
  - Response: fsm_busy high from the miss cycle; write_data_array pulses 8 times with word_num 0..7; write_tag_array on the 8th pulse only; the 9th and 10th valids produce no writes; fsm_busy low afterwards.
- Address sequence: miss_address=16'hABCE -> memory_address steps 16'hABC0, ABC2 ... ABCE, then holds ABCE.
- Ignored inputs:
  - memory_data_valid=1 in IDLE -> no write.
  - miss_detected mid-fill with miss_address=16'h1230 -> base unchanged and the fill completes normally.
- Reset mid-fill: assert rst after 3 words -> immediate IDLE, no write_tag_array. The next miss restarts at word 0.
- CWF (macro defined): miss_address=16'h00A6 -> first memory_address=16'h00A6; word_num sequence 3,4,5,6,7,0,1,2; tag write coincides with word 2.
